// File: rtl/tone_seq_channels_if.sv
// Command and status bundle for the tone sequencer: one write port in, per-channel status out.
interface tone_seq_channels_if #(
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 24,
    parameter int DUR_WIDTH = 16,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                 wr_en;
    logic [CH_W-1:0]      wr_ch;
    logic [DIV_WIDTH-1:0] wr_half_period;
    logic [DUR_WIDTH-1:0] wr_duration;
    logic [CHANNELS-1:0]  tone_out;
    logic [CHANNELS-1:0]  busy;
    logic [CHANNELS-1:0]  done;

    modport master (
        output wr_en, wr_ch, wr_half_period, wr_duration,
        input  tone_out, busy, done
    );

    modport slave (
        input  wr_en, wr_ch, wr_half_period, wr_duration,
        output tone_out, busy, done
    );
endinterface

// File: rtl/tone_seq_channels.sv
// Multi-channel square-wave tone sequencer with per-channel timed notes and a shared ms-tick prescaler.
// Latency: commands take effect at the sampling edge; no backpressure, every in-range command is accepted.
module tone_seq_channels #(
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 24,
    parameter int DUR_WIDTH = 16,
    parameter int TICK_DIV  = 50000,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    tone_seq_channels_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic {IDLE, PLAYING} state_e;

    logic [PW-1:0]        presc_q, presc_d;
    logic                 tick;

    state_e               state_q [CHANNELS];
    state_e               state_d [CHANNELS];
    logic [DIV_WIDTH-1:0] hp_q    [CHANNELS];
    logic [DIV_WIDTH-1:0] hp_d    [CHANNELS];
    logic [DIV_WIDTH-1:0] div_q   [CHANNELS];
    logic [DIV_WIDTH-1:0] div_d   [CHANNELS];
    logic [DUR_WIDTH-1:0] dur_q   [CHANNELS];
    logic [DUR_WIDTH-1:0] dur_d   [CHANNELS];
    logic [DUR_WIDTH-1:0] rem_q   [CHANNELS];
    logic [DUR_WIDTH-1:0] rem_d   [CHANNELS];
    logic [CHANNELS-1:0]  tone_q, tone_d;
    logic [CHANNELS-1:0]  done_q, done_d;
    logic [CHANNELS-1:0]  busy_w;

    always_comb begin
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        div_d   = div_q;
        dur_d   = dur_q;
        rem_d   = rem_q;
        tone_d  = tone_q;
        done_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // Out-of-range channel numbers match no loop index and are dropped.
            if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
                if (bus.wr_half_period != '0) begin
                    state_d[i] = PLAYING;
                    hp_d[i]    = bus.wr_half_period;
                    dur_d[i]   = bus.wr_duration;
                    rem_d[i]   = bus.wr_duration;
                    div_d[i]   = '0;
                    tone_d[i]  = 1'b0;
                end else begin
                    state_d[i] = IDLE;
                    tone_d[i]  = 1'b0;
                end
            end else if (state_q[i] == PLAYING) begin
                if (tick && (dur_q[i] != '0) && (rem_q[i] == DUR_WIDTH'(1))) begin
                    state_d[i] = IDLE;
                    tone_d[i]  = 1'b0;
                    done_d[i]  = 1'b1;
                    rem_d[i]   = '0;
                end else begin
                    if (tick && (dur_q[i] != '0)) begin
                        rem_d[i] = rem_q[i] - DUR_WIDTH'(1);
                    end
                    if (div_q[i] == (hp_q[i] - DIV_WIDTH'(1))) begin
                        div_d[i]  = '0;
                        tone_d[i] = ~tone_q[i];
                    end else begin
                        div_d[i]  = div_q[i] + DIV_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tone_q  <= '0;
            done_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                hp_q[i]    <= '0;
                div_q[i]   <= '0;
                dur_q[i]   <= '0;
                rem_q[i]   <= '0;
            end
        end else begin
            presc_q <= presc_d;
            tone_q  <= tone_d;
            done_q  <= done_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                hp_q[i]    <= hp_d[i];
                div_q[i]   <= div_d[i];
                dur_q[i]   <= dur_d[i];
                rem_q[i]   <= rem_d[i];
            end
        end
    end

    always_comb begin
        busy_w = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy_w[i] = (state_q[i] == PLAYING);
        end
    end

    assign bus.tone_out = tone_q;
    assign bus.busy     = busy_w;
    assign bus.done     = done_q;
endmodule

// File: doc/tone_seq_channels.md
TONE_SEQ_CHANNELS -- requirements
Module: tone_seq_channels

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- CHANNELS, 4: number of independent tone channels; legal range 1..16.
- DIV_WIDTH, 24: width of the half-period divider.
- DUR_WIDTH, 16: width of the duration count, in ticks.
- TICK_DIV, 50000: clk cycles per duration tick (1 ms at 50 MHz); minimum 2.
- CH_W, $clog2(CHANNELS) with a minimum of 1: channel index width (derived).
REQ-002 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- wr_en, in, 1: command strobe, sampled on every rising clk edge.
- wr_ch, in, CH_W: target channel.
- wr_half_period, in, DIV_WIDTH: clk cycles per output half-period; 0 means stop.
- wr_duration, in, DUR_WIDTH: play length in ticks; 0 means continuous.
- tone_out, out, CHANNELS: per-channel square wave.
- busy, out, CHANNELS: per-channel PLAYING indicator.
- done, out, CHANNELS: one-cycle pulse when a timed note expires.

Function
REQ-004 Each channel SHALL have a 2-state FSM, IDLE and PLAYING; busy[i] SHALL equal (state == PLAYING).
REQ-005 In IDLE, tone_out[i] SHALL be 0 and the channel's counters SHALL hold.
REQ-006 A command is wr_en=1 with wr_ch < CHANNELS; when wr_ch >= CHANNELS the command SHALL be ignored with no state change.
REQ-007 A command with wr_half_period != 0 SHALL, at the sampling edge:
- latch half_period and duration;
- clear the divider counter and tone_out[i];
- enter PLAYING.
This applies from either state; a command to a PLAYING channel restarts the note.
REQ-008 A command with wr_half_period == 0 SHALL force IDLE with tone_out[i]=0 and SHALL NOT pulse done.
REQ-009 Divider: in PLAYING, the counter SHALL increment each cycle.
- At count == half_period-1 it SHALL wrap to 0 and tone_out[i] SHALL toggle.
- The first rising edge of tone_out[i] occurs exactly half_period cycles after the load edge.
- Output period SHALL be 2*half_period cycles at 50% duty.
- half_period == 1 gives a toggle every cycle.
REQ-010 A single free-running tick prescaler SHALL count 0..TICK_DIV-1 and assert an internal one-cycle tick at TICK_DIV-1; it is shared by all channels and never reset by commands.
REQ-011 Duration: in PLAYING with a nonzero latched duration, remaining SHALL decrement on each tick.
- On the tick where remaining == 1 the channel SHALL enter IDLE, drive tone_out[i]=0, and pulse done[i] for exactly one cycle.
- Played time SHALL lie between (duration-1)*TICK_DIV+1 and duration*TICK_DIV cycles.
REQ-012 When the latched duration is 0, the channel SHALL play until stopped or reset and SHALL never assert done.
REQ-013 Simultaneous expiry and command on the same channel and edge: the command SHALL win, done SHALL NOT pulse, and the new note SHALL start per REQ-007.
REQ-014 Channels SHALL be fully independent; a command to channel i SHALL NOT alter any state of channel j != i.
REQ-015 Counter arithmetic SHALL be unsigned at the declared widths, with no overflow possible (divider < half_period, remaining <= duration).

Reset
REQ-016 While reset=1 at a clk edge, all of the following SHALL clear regardless of wr_en:
- all channels to IDLE;
- tone_out, busy, done to 0;
- divider counters, remaining counts, and the tick prescaler to 0.
REQ-017 Reset asserted mid-note SHALL abort the note without a done pulse; the first command is accepted on the first edge with reset=0.

Verification
REQ-018 The bench SHALL cover, with TICK_DIV=4 and CHANNELS=4:
- Reset, then write ch0 hp=3 dur=0 -> busy[0]=1 next cycle; tone_out[0] rises 3 cycles after the load edge with period 6; it runs indefinitely with no done.
- Write ch1 hp=2 dur=3 -> busy[1] falls and done[1] pulses once, within 9..12 cycles after load; tone_out[1]=0 afterwards.
- Restart: write ch2 hp=5 dur=0, then after 7 cycles write ch2 hp=2 -> tone_out[2] clears at the write edge and first rises 2 cycles later.
- Stop and ignore: write ch0 hp=0 while playing -> IDLE with no done; a write with wr_ch=5 (CH_W=2 with CHANNELS=4 cannot encode 5, so rerun the bench at CHANNELS=3, write wr_ch=3) -> no output change.
- Collision: a write to ch1 on its expiry edge -> no done; the new note starts. Reset asserted mid-note on ch3 -> all outputs 0 next cycle.
- Independence: all 4 channels with hp = 1, 2, 3, 4 -> periods 2, 4, 6, 8 hold concurrently; a write to one channel leaves the others' phase unchanged.
